// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: latches a byte on tx_valid and shifts it out LSB first
// as start, 8 data bits, then STOP_BITS stop bits, each CLKS_PER_BIT cycles wide.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_tx
);

  // state | meaning
  // IDLE  | line high, waiting for tx_valid
  // START | start bit (line low)
  // DATA  | data bits, LSB first, bit index in bit_idx_q
  // STOP  | stop bit(s), line high, stop index in stop_cnt_q
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign baud_last = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        // Requests arriving while busy never reach this branch, so they are dropped.
        if (tx_valid) begin
          state_d    = START;
          shift_d    = tx_data;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (stop_cnt_q == STOP_LAST) state_d = IDLE;
          else                         stop_cnt_d = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered pins line up with it.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign uart_tx = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: scoreboard of sent bytes, cycle-exact frame decoder.
// Instance 1 uses one stop bit, instance 2 uses two.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid1, tx_valid2;
  logic       busy1, done1, line1;
  logic       busy2, done2, line2;

  logic [7:0] exp_q[$];
  int         vec_cnt = 0;
  int         err_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid1),
    .tx_busy(busy1), .tx_done(done1), .uart_tx(line1)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid2),
    .tx_busy(busy2), .tx_done(done2), .uart_tx(line2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic get_line(input int sel);
    return (sel != 0) ? line2 : line1;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy2 : busy1;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel != 0) ? done2 : done1;
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel != 0) tx_valid2 = v;
    else          tx_valid1 = v;
  endtask

  // Called at a negedge in cycle 0; returns at the negedge of cycle 1.
  task automatic send(input int sel, input logic [7:0] data, input bit push);
    tx_data = data;
    set_valid(sel, 1'b1);
    if (push) exp_q.push_back(data);
    @(negedge clk);
    set_valid(sel, 1'b0);
    tx_data = ~data;
  endtask

  // Starts at the negedge of the first start-bit cycle, returns at the done cycle.
  task automatic rx_frame(input int sel, input int stop_bits, input int inject_at,
                          input logic [7:0] inject_data);
    logic       bits [11];
    logic       hold_ok, busy_ok, done_seen, stop_ok, l;
    logic [7:0] got;
    int         cyc;
    hold_ok   = 1'b1;
    busy_ok   = 1'b1;
    done_seen = 1'b0;
    cyc       = 1;
    for (int b = 0; b < 9 + stop_bits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        l = get_line(sel);
        if (c == 0) bits[b] = l;
        else if (l !== bits[b]) hold_ok = 1'b0;
        if (get_busy(sel) !== 1'b1) busy_ok = 1'b0;
        if (get_done(sel) !== 1'b0) done_seen = 1'b1;
        if (cyc == inject_at) begin
          tx_data = inject_data;
          set_valid(sel, 1'b1);
        end else if (cyc == inject_at + 1) begin
          set_valid(sel, 1'b0);
        end
        cyc++;
        @(negedge clk);
      end
    end
    for (int i = 0; i < 8; i++) got[i] = bits[i+1];
    stop_ok = 1'b1;
    for (int i = 9; i < 9 + stop_bits; i++) if (bits[i] !== 1'b1) stop_ok = 1'b0;
    chk("start_bit", 32'(bits[0]), 32'd0);
    chk("stop_bits", 32'(stop_ok), 32'd1);
    chk("bit_hold", 32'(hold_ok), 32'd1);
    chk("busy_in_frame", 32'(busy_ok), 32'd1);
    chk("done_early", 32'(done_seen), 32'd0);
    chk("done_pulse", 32'(get_done(sel)), 32'd1);
    chk("busy_clear", 32'(get_busy(sel)), 32'd0);
    chk("idle_line", 32'(get_line(sel)), 32'd1);
    chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) chk("byte", 32'(got), 32'(exp_q.pop_front()));
  endtask

  initial begin
    logic ok;
    resetn    = 1'b0;
    tx_data   = 8'h00;
    tx_valid1 = 1'b0;
    tx_valid2 = 1'b0;

    // Reset and idle line
    repeat (3) @(negedge clk);
    chk("rst_line", 32'(line1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_line2", 32'(line2), 32'd1);
    resetn = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (line1 !== 1'b1 || busy1 !== 1'b0 || line2 !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    chk("idle_high", 32'(ok), 32'd1);

    // Single byte 0x55
    send(0, 8'h55, 1'b1);
    rx_frame(0, 1, -1, 8'h00);
    @(negedge clk);
    chk("done_one_cycle", 32'(done1), 32'd0);
    repeat (3) @(negedge clk);

    // Back-to-back: second request in the done cycle
    send(0, 8'hA5, 1'b1);
    rx_frame(0, 1, -1, 8'h00);
    send(0, 8'h3C, 1'b1);
    rx_frame(0, 1, -1, 8'h00);
    @(negedge clk);
    chk("b2b_done_low", 32'(done1), 32'd0);
    repeat (3) @(negedge clk);

    // Request while busy is ignored
    send(0, 8'h0F, 1'b1);
    rx_frame(0, 1, 15, 8'hFF);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (line1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) ok = 1'b0;
    end
    chk("no_second_frame", 32'(ok), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of DATA abandons the frame
    send(0, 8'h00, 1'b0);
    ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (line1 !== 1'b0 || busy1 !== 1'b1) ok = 1'b0;
      if (c == 20) resetn = 1'b0;
      @(negedge clk);
    end
    resetn = 1'b1;
    chk("pre_rst_low", 32'(ok), 32'd1);
    chk("midrst_line", 32'(line1), 32'd1);
    chk("midrst_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    chk("midrst_stays_idle", 32'(busy1), 32'd0);
    repeat (2) @(negedge clk);
    send(0, 8'h81, 1'b1);
    rx_frame(0, 1, -1, 8'h00);
    repeat (3) @(negedge clk);

    // Two stop bits
    send(1, 8'hC3, 1'b1);
    rx_frame(1, 2, -1, 8'h00);
    @(negedge clk);
    chk("stop2_done_low", 32'(done2), 32'd0);
    chk("stop2_line", 32'(line2), 32'd1);
    chk("dut1_quiet", 32'(busy1), 32'd0);
    chk("sb_final", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
